// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown datapath: FSM state encoding and
// default sizing used by countdown_ctrl, the down counter and the display.
package countdown_ctrl_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MAX_VAL_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/countdown_ctrl_one_pulse.sv
// Rising-edge detector: turns a synchronised button level into a single
// clk-wide command pulse, however long the button is held.
module one_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // Level history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Control FSM for the down-counter datapath: button commands, load/enable
// strobes to the counter, terminal-count detection and done blinking.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_VAL   = MAX_VAL_DEF,
  parameter int BLINK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start_btn,
  input  logic             load_btn,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_en,
  output logic [2:0]       state_o,
  output logic             done,
  output logic             done_blink
);

  localparam int               BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);

  state_e           state_q, state_d;
  logic             cnt_load_q, cnt_load_d;
  logic             cnt_en_q, cnt_en_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic             done_q, done_d;
  logic             blink_q, blink_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;

  logic             start_p, load_p;
  logic [WIDTH-1:0] preset_c;

  one_pulse u_start_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (start_btn),
    .pulse_o (start_p)
  );

  one_pulse u_load_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (load_btn),
    .pulse_o (load_p)
  );

  assign preset_c = (init_val > MAX_W) ? MAX_W : init_val;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_load_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_data_q <= '0;
      done_q     <= 1'b0;
      blink_q    <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_load_q <= cnt_load_d;
      cnt_en_q   <= cnt_en_d;
      cnt_data_q <= cnt_data_d;
      done_q     <= done_d;
      blink_q    <= blink_d;
      bcnt_q     <= bcnt_d;
    end
  end

  // Next state and next output values; load is handled ahead of the per-state
  // case since it wins in every state and always lands in READY with a reload
  always_comb begin
    state_d    = state_q;
    cnt_load_d = 1'b0;
    cnt_en_d   = 1'b0;
    cnt_data_d = cnt_data_q;
    blink_d    = blink_q;
    bcnt_d     = bcnt_q;

    if (load_p) begin
      state_d    = ST_READY;
      cnt_load_d = 1'b1;
      cnt_data_d = preset_c;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_READY: begin
          if (start_p) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start_p) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (cnt_val != '0) begin
              cnt_en_d = 1'b1;
            end else begin
              state_d = ST_DONE;
              blink_d = 1'b1;
              bcnt_d  = '0;
            end
          end
        end
        ST_PAUSE: begin
          if (start_p) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start_p) begin
            // Restart the same preset: reload the held cnt_data
            state_d    = ST_READY;
            cnt_load_d = 1'b1;
          end else if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
              blink_d = ~blink_q;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != ST_DONE) blink_d = 1'b0;
    done_d = (state_d == ST_DONE);
  end

  assign state_o    = state_q;
  assign cnt_load   = cnt_load_q;
  assign cnt_en     = cnt_en_q;
  assign cnt_data   = cnt_data_q;
  assign done       = done_q;
  assign done_blink = blink_q;

endmodule
